// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
// Module : sub_pkg
// Brief  : Shared types and defaults for the bit-serial subtractor.
// Rev    : 1.0
// ============================================================================
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int SUB_WIDTH_DEFAULT = 4;

endpackage : sub_pkg
`default_nettype wire

// File: rtl/serial_subtractor_4bit_if.sv
`default_nettype none
// ============================================================================
// Module : serial_subtractor_4bit_if
// Brief  : Operand/result handshake bundle for the serial subtractor.
// Rev    : 1.0
// ============================================================================
interface serial_subtractor_4bit_if #(
    parameter int WIDTH = sub_pkg::SUB_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             V;

    modport master (
        output start, A, B, Bin,
        input  busy, done, Diff, Bout, V
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, Diff, Bout, V
    );
endinterface : serial_subtractor_4bit_if
`default_nettype wire

// File: rtl/full_subtractor_bit.sv
`default_nettype none
// ============================================================================
// Module : full_subtractor_bit
// Brief  : One-bit full subtractor, d = a - b - bin with borrow out.
// Rev    : 1.0
// ============================================================================
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule : full_subtractor_bit
`default_nettype wire

// File: rtl/serial_subtractor_4bit.sv
`default_nettype none
// ============================================================================
// Module : serial_subtractor_4bit
// Brief  : Bit-serial ripple subtractor, Diff = A - B - Bin, LSB first.
// Rev    : 1.0
// ============================================================================
module serial_subtractor_4bit
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serial_subtractor_4bit_if.slave  bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] dsh_q, dsh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_d;
    logic             bit_bout;

    // Operands shift right so the current bit is always at index 0.
    full_subtractor_bit u_fsb (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        dsh_d   = dsh_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        v_d     = v_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    br_d    = bus.Bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = bit_bout;
                dsh_d = {bit_d, dsh_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // a_q[0]/b_q[0] hold the original sign bits on this last step.
                    cnt_d   = '0;
                    diff_d  = {bit_d, dsh_q[WIDTH-1:1]};
                    bout_d  = bit_bout;
                    v_d     = (a_q[0] ^ b_q[0]) & (a_q[0] ^ bit_d);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dsh_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dsh_q   <= dsh_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;
    assign bus.V    = v_q;

endmodule : serial_subtractor_4bit
`default_nettype wire

// File: tb/tb_serial_subtractor_4bit.sv
`default_nettype none
// ============================================================================
// Module : tb_serial_subtractor_4bit
// Brief  : Directed self-checking bench for the bit-serial subtractor.
// Rev    : 1.0
// ============================================================================
module tb_serial_subtractor_4bit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serial_subtractor_4bit_if #(.WIDTH(4)) bus ();

    serial_subtractor_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference: 5-bit unsigned subtraction and true signed range test.
    task automatic model(input logic [3:0] a, input logic [3:0] b, input logic bin,
                         output logic [3:0] ed, output logic eb, output logic ev);
        logic [4:0] r;
        int         s;
        r  = {1'b0, a} - {1'b0, b} - {4'b0, bin};
        ed = r[3:0];
        eb = r[4];
        s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
        ev = (s < -8) || (s > 7);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                          input logic [3:0] ed, input logic eb, input logic ev);
        bus.A = a; bus.B = b; bus.Bin = bin; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("busy_run", bus.busy, 1);
            chk("done_run", bus.done, 0);
            tick();
        end
        chk("done_pulse", bus.done, 1);
        chk("busy_done", bus.busy, 1);
        chk($sformatf("diff %0d-%0d-%0d", a, b, bin), bus.Diff, ed);
        chk($sformatf("bout %0d-%0d-%0d", a, b, bin), bus.Bout, eb);
        chk($sformatf("v %0d-%0d-%0d", a, b, bin), bus.V, ev);
        tick();
        chk("done_clear", bus.done, 0);
        chk("busy_clear", bus.busy, 0);
        chk("diff_hold", bus.Diff, ed);
    endtask

    initial begin
        logic [3:0] ed;
        logic       eb;
        logic       ev;

        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
        tick(); tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_diff", bus.Diff, 0);
        chk("rst_bout", bus.Bout, 0);
        chk("rst_v", bus.V, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 9-3: -7-3 = -10 overflows the signed range, so V is set.
        run_op(4'd9, 4'd3, 1'b0, 4'h6, 1'b0, 1'b1);
        run_op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1);
        run_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
        run_op(4'd7, 4'd8, 1'b0, 4'hF, 1'b1, 1'b1);
        run_op(4'd8, 4'd0, 1'b1, 4'h7, 1'b0, 1'b1);

        // start plus new operands during RUN/DONE must be ignored.
        bus.A = 4'd9; bus.B = 4'd3; bus.Bin = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.A = 4'd1; bus.B = 4'd2; bus.Bin = 1'b1; bus.start = 1'b1;
        tick();
        chk("ign_busy", bus.busy, 1);
        tick();
        tick();
        chk("ign_done", bus.done, 1);
        chk("ign_diff", bus.Diff, 4'h6);
        chk("ign_bout", bus.Bout, 0);
        bus.start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("ign_single_done", bus.done, 0);
            chk("ign_diff_hold", bus.Diff, 4'h6);
        end

        // start held high: one result every 6 cycles.
        bus.A = 4'd7; bus.B = 4'd8; bus.Bin = 1'b0; bus.start = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            chk($sformatf("b2b_done k=%0d", k), bus.done, ((k % 6) == 4) ? 1 : 0);
            if ((k % 6) == 4) chk("b2b_diff", bus.Diff, 4'hF);
        end
        bus.start = 1'b0;
        tick();
        chk("b2b_idle", bus.busy, 0);

        // Async reset while bit 2 is pending.
        bus.A = 4'd9; bus.B = 4'd3; bus.Bin = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_diff", bus.Diff, 0);
        chk("arst_bout", bus.Bout, 0);
        chk("arst_v", bus.V, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_stay_idle", bus.busy, 0);
        run_op(4'd5, 4'd5, 1'b0, 4'h0, 1'b0, 1'b0);

        // Full operand sweep against the reference model.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v9;
            v9 = 9'(i);
            model(v9[8:5], v9[4:1], v9[0], ed, eb, ev);
            run_op(v9[8:5], v9[4:1], v9[0], ed, eb, ev);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_subtractor_4bit
`default_nettype wire
